// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary-to-BCD front end for a multiplexed 7-segment display.
// A sequential double-dabble engine converts a saturated binary value to BCD.
// The result is committed to the display register in one step, with leading
// zeros blanked to 4'hF. A free-running scanner then presents one nibble per
// slot, together with an active-low one-hot digit enable.
module seg7_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic [3:0]        digit_val,
  output logic [DIGITS-1:0] digit_sel
);

  // 10^n evaluated at elaboration time; wide enough for up to 8 digits.
  function automatic longint pow10(input int n);
    longint r;
    r = 64'sd1;
    for (int i = 0; i < n; i++) r = r * 64'sd10;
    return r;
  endfunction

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DATA_W-1:0] MAX_VAL    = DATA_W'(pow10(DIGITS) - 64'sd1);
  // The reset display shows "0": every digit blank except the rightmost digit.
  localparam logic [BCD_W-1:0]  RESET_DISP = ~BCD_W'(4'hF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the whole register left.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[DATA_W+4*i +: 4] >= 4'd5) t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
      else                            t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4];
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  // Replace leading zero nibbles with blank codes. Digit 0 is never blanked.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = bcd;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else                                 lead = 1'b0;
    end
    return r;
  endfunction

  state_t                     state_q;
  logic                       busy_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [SH_W-1:0]            sh_q;
  logic [DATA_W-1:0]          sat_s;
  logic [PRE_W-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]     disp_q, disp_d;
  logic [DIGITS-1:0]          sel_q, sel_d;
  logic [3:0]                 val_q, val_d;

  assign busy      = busy_q;
  assign digit_val = val_q;
  assign digit_sel = sel_q;

  // Clamp the input to the largest value the display can show.
  always_comb begin
    if (bin_in > MAX_VAL) sat_s = MAX_VAL;
    else                  sat_s = bin_in;
  end

  // Conversion FSM: capture on load, run DATA_W dabble iterations, then commit for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sh_q    <= {SH_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            sh_q    <= SH_W'(sat_s);
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          sh_q <= dabble_step(sh_q);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_COMMIT;
          else                             cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position and display contents. The outputs are registered from
  // the next-state values so that the enable and the nibble always change together.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = {PRE_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = {IDX_W{1'b0}};
      else                             idx_d = idx_q + IDX_W'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
    end
    if (state_q == S_COMMIT) disp_d = blank_lz(sh_q[SH_W-1 -: BCD_W]);
    else                     disp_d = disp_q;
    sel_d = ~(DIGITS'(1'b1) << idx_d);
    val_d = disp_d[idx_d];
  end

  // Scanner, display register and registered digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= {PRE_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      disp_q  <= RESET_DISP;
      sel_q   <= ~DIGITS'(1'b1);
      val_q   <= 4'h0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl. Stimulus issues loads and pushes the expected
// display and completion cycle onto a queue. A negedge monitor pops an entry
// whenever busy falls, and it checks the scanned outputs in every cycle.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DATA_W = 14;
  localparam int RDIV   = 4;
  localparam int LAT    = DATA_W + 2;   // load cycle to the cycle in which busy falls

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [DATA_W-1:0] bin_in = '0;
  logic              busy;
  logic [3:0]        digit_val;
  logic [DIGITS-1:0] digit_sel;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DATA_W(DATA_W), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .load(load), .bin_in(bin_in),
    .busy(busy), .digit_val(digit_val), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] disp;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_at = 0;
  int   errors = 0;
  int   checks = 0;

  // Free-running cycle counter, advanced on the active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // Reference display: saturate, split into decimal digits, blank digit i (i>0) when the value is < 10^i.
  function automatic logic [15:0] model_disp(input int unsigned b);
    int unsigned v, p;
    logic [15:0] r;
    v = (b > 9999) ? 9999 : b;
    p = 1;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
      else                r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a single-cycle load. The model decides whether an idle converter accepts it.
  task automatic pulse_load(input int unsigned v);
    exp_t e;
    load   = 1'b1;
    bin_in = DATA_W'(v);
    if (cyc >= free_at) begin
      e.disp = model_disp(v);
      e.due  = cyc + LAT;
      q.push_back(e);
      free_at = cyc + LAT;
    end
    idle(1);
    load = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_at) idle(1);
  endtask

  // Monitor state.
  logic        rst_prev = 1'b0;
  logic        active = 1'b0;
  int          scan_base = 0;
  int          busy_len = 0;
  logic [15:0] exp_disp = 16'hFFF0;

  // Monitor: track busy pulses, pop the expectation on each completion, and check the scan every cycle.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    logic [3:0] es;
    if (rst_prev) begin
      active    = 1'b1;
      scan_base = cyc;
      exp_disp  = 16'hFFF0;
      busy_len  = 0;
      chk("busy_reset", 32'(busy), 32'd0);
    end else if (active) begin
      if (busy === 1'b1) begin
        busy_len++;
        if (busy_len > 40) begin
          chk("busy_stuck", 32'(busy_len), 32'(DATA_W + 1));
          busy_len = 0;
        end
      end else if (busy_len > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(busy_len), 32'd0);
        end else begin
          e = q.pop_front();
          chk("busy_len", 32'(busy_len), 32'(DATA_W + 1));
          chk("done_cycle", 32'(cyc), 32'(e.due));
          exp_disp = e.disp;
        end
        busy_len = 0;
      end
    end
    if (active) begin
      idx = ((cyc - scan_base) / RDIV) % DIGITS;
      es  = ~(4'b0001 << idx);
      chk("digit_sel", 32'(digit_sel), 32'(es));
      chk("digit_val", 32'(digit_val), 32'(exp_disp[4*idx +: 4]));
    end
    rst_prev = rst;
  end

  // Watchdog so that the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int unsigned v;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);

    // Directed conversions: normal value, leading zeros, interior zeros, saturation.
    pulse_load(1234);  wait_free(); idle(20);
    pulse_load(7);     wait_free(); idle(18);
    pulse_load(0);     wait_free(); idle(18);
    pulse_load(1005);  wait_free(); idle(18);
    pulse_load(16383); wait_free(); idle(18);
    pulse_load(10000); wait_free(); idle(18);

    // A load three cycles into a conversion is ignored. A load in the cycle busy falls is accepted.
    pulse_load(1234);
    idle(2);
    pulse_load(5678);
    wait_free();
    pulse_load(5678);
    wait_free(); idle(20);

    // A reset during a conversion aborts it and restores the "0" display.
    pulse_load(4321);
    idle(4);
    rst = 1'b1;
    q.delete();
    free_at = 0;
    idle(1);
    rst = 1'b0;
    idle(24);

    // Randomized loads with random gaps, so that some of them land while busy.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 16383);
        default: v = $urandom_range(9990, 16383);
      endcase
      idle($urandom_range(0, 22));
      pulse_load(v);
    end
    wait_free();
    idle(40);
    chk("pending_expectations", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Front-end for the multiplexed 4-digit 7-segment display. It accepts a binary value and converts it to BCD with a sequential double-dabble engine, blanking leading zeros. It then scans the digits at a fixed refresh rate, presenting one nibble per time slot together with an active-low digit enable. `digit_val` drives the `value` input of the existing active-low segment decoder directly. The decoder blanks any code of 10–15, so this block uses code 4'hF as its blank.

## Interface
- `DIGITS`, 4, number of display digits (1–8).
- `DATA_W`, 14, width of binary input; must satisfy 2^DATA_W > 10^DIGITS − 1.
- `REFRESH_DIV`, 50000, clk cycles per digit slot (≥ 2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to convert `bin_in`.
- `bin_in`  in  DATA_W  unsigned value to display.
- `busy`  out  1  high while a conversion is in progress.
- `digit_val`  out  4  BCD nibble or 4'hF blank for the active digit, to the decoder.
- `digit_sel`  out  DIGITS  active-low one-hot digit enable; bit 0 = rightmost (least significant) digit.

## Operation
- Conversion FSM states:
  - IDLE → SHIFT on `load`=1 (only when in IDLE).
  - SHIFT: runs DATA_W iterations. Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts the {BCD, bin} register left 1.
  - SHIFT → COMMIT after iteration DATA_W.
  - COMMIT → IDLE after 1 cycle.
- Capture: `bin_in` is latched on the accepted `load` cycle. If `bin_in` > 10^DIGITS − 1, the latched value saturates to 10^DIGITS − 1 (4 digits: 9999). The BCD register is 4·DIGITS bits wide; no overflow is possible after saturation.
- `load` while `busy`=1 is ignored; it is not queued.
- COMMIT writes the display register in one step, so the display never shows partial results.
  - Leading-zero blanking: scanning from the most significant digit, every zero nibble before the first non-zero nibble becomes 4'hF.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Scan:
  - Prescaler counts 0..REFRESH_DIV−1 and wraps.
  - At terminal count the digit index advances by 1, wrapping DIGITS−1 → 0.
- The scan runs continuously and independently of the FSM. The display register changes only at COMMIT; the current slot immediately shows the new nibble.
- Output decode:
  - `digit_sel` = ~(1 << index).
  - `digit_val` = display[index].
  - Both registered and updated in the same cycle, so the enable and the value never mismatch.

## Timing
- Reset values:
  - FSM IDLE, `busy`=0, prescaler 0, index 0.
  - `digit_sel` = all ones except bit 0 = 0.
  - Display register = {F,…,F,0}; `digit_val`=0.
- Reset mid-conversion aborts the conversion and restores the reset display ("0"); it does not complete the commit.
- Load accepted in cycle N:
  - `busy`=1 from N+1 through N+DATA_W+1 (SHIFT DATA_W cycles + COMMIT 1 cycle).
  - New display values are visible on `digit_val` from cycle N+DATA_W+2.
  - `busy`=0 again in N+DATA_W+2.
- A `load` in the same cycle that `busy` falls is accepted (FSM is in IDLE).
- Digit index advances in the cycle after the prescaler reaches REFRESH_DIV−1.
  - Full refresh period = DIGITS·REFRESH_DIV cycles.
  - Each `digit_sel` bit is low for exactly REFRESH_DIV consecutive cycles.
- Exactly one `digit_sel` bit is low in every cycle, including during reset release.

## Test plan
Use REFRESH_DIV=4, DIGITS=4, DATA_W=14 for all scenarios.
- Reset: assert `rst` 3 cycles → `busy`=0, `digit_sel`=4'b1110, `digit_val`=0. A full scan shows slots 1–3 = 4'hF and slot 0 = 0.
- Convert 1234: pulse `load` with `bin_in`=1234 → `busy` high for exactly 15 cycles. Then slots 0..3 show 4, 3, 2, 1, each slot lasting 4 cycles in the order 1110, 1101, 1011, 0111.
- Leading zeros: `bin_in`=7 → slots show 7, F, F, F. `bin_in`=0 → 0, F, F, F. `bin_in`=1005 → 5, 0, 0, 1 (interior zeros not blanked).
- Saturation: `bin_in`=16383 → display 9, 9, 9, 9. `bin_in`=10000 → 9, 9, 9, 9.
- Load while busy: `load` 1234, then `load` 5678 three cycles later → second request ignored; final display 1234 and `busy` pulse length 15. Then `load` 5678 in the cycle `busy` falls → accepted; final display 5678.
- Reset mid-conversion: `load` 4321, assert `rst` 5 cycles later → `busy`=0 next cycle; display shows "0". The 4321 value never appears.
